multicycle_alu: RTL and testbench

- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Performs the RV32I integer ALU operations on two registered operands.
- Logic and arithmetic ops complete in one cycle; shifts iterate one bit position per cycle, freeing timing on the shifter.
- Start/busy/done handshake toward the multicycle core control FSM.

---
 rtl/multicycle_alu.sv | 151 +++++++++++++++
 tb/tb_multicycle_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// Multicycle RV32I ALU: single-cycle logic/arith/compare ops, shifts done one bit per cycle.
// Latency: 1 cycle for non-shift ops and zero-length shifts, shamt+1 cycles for shifts.
// Backpressure: start is only accepted in IDLE; busy covers SHIFT and DONE, start is ignored there.
module multicycle_alu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            operation,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] alu_result,
   output logic                  zero
);

   localparam int SHAMT_W = $clog2(DATA_WIDTH);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRL = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BNE = 4'b1001;
   localparam logic [3:0] OP_BLT = 4'b1010;
   localparam logic [3:0] OP_BGE = 4'b1011;
   localparam logic [3:0] OP_SLT = 4'b1100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [SHAMT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  zero_q, zero_d;

   logic [DATA_WIDTH-1:0] calc_res;
   logic [DATA_WIDTH-1:0] shift_step;
   logic [SHAMT_W-1:0]    shamt;
   logic                  is_shift;
   logic                  lt_signed;

   assign shamt     = src_b[SHAMT_W-1:0];
   assign is_shift  = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);
   assign lt_signed = $signed(src_a) < $signed(src_b);

   // Single-cycle result from the live inputs; a shift here only covers shamt==0, which returns A.
   always_comb begin
      calc_res = '0;
      case (operation)
         OP_AND:  calc_res = src_a & src_b;
         OP_OR:   calc_res = src_a | src_b;
         OP_ADD:  calc_res = src_a + src_b;
         OP_XOR:  calc_res = src_a ^ src_b;
         OP_SUB:  calc_res = src_a - src_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  calc_res = src_a;
         OP_SLT,
         OP_BLT:  calc_res = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
         OP_BGE:  calc_res = {{(DATA_WIDTH-1){1'b0}}, ~lt_signed};
         OP_BEQ:  calc_res = {{(DATA_WIDTH-1){1'b0}}, (src_a == src_b)};
         OP_BNE:  calc_res = {{(DATA_WIDTH-1){1'b0}}, (src_a != src_b)};
         default: calc_res = '0;
      endcase
   end

   // One-bit shift of the accumulator according to the latched opcode.
   always_comb begin
      shift_step = acc_q;
      case (op_q)
         OP_SLL:  shift_step = {acc_q[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  shift_step = {1'b0, acc_q[DATA_WIDTH-1:1]};
         OP_SRA:  shift_step = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
         default: shift_step = acc_q;
      endcase
   end

   // Next-state logic: accept in IDLE, iterate in SHIFT, one-cycle DONE pulse back to IDLE.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = operation;
               acc_d = src_a;
               if (is_shift && (shamt != '0)) begin
                  cnt_d   = shamt;
                  state_d = S_SHIFT;
               end else begin
                  result_d = calc_res;
                  zero_d   = (calc_res == '0);
                  state_d  = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            acc_d = shift_step;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               result_d = shift_step;
               zero_d   = (shift_step == '0);
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign alu_result = result_q;
   assign zero       = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu with hand-computed expected results.
// Latency: checks done latency in edges counted from the accepting edge.
// Backpressure: exercises start-while-busy, input changes mid-shift and back-to-back starts.
module tb_multicycle_alu;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  operation;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        done;
   logic [31:0] alu_result;
   logic        zero;

   int errors = 0;
   int checks = 0;

   multicycle_alu #(.DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .operation  (operation),
      .src_a      (src_a),
      .src_b      (src_b),
      .busy       (busy),
      .done       (done),
      .alu_result (alu_result),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue one operation, measure latency, check result and the single-cycle done pulse.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                         input int exp_lat, input bit interfere);
      int lat;
      @(negedge clk);
      start     = 1'b1;
      operation = op;
      src_a     = a;
      src_b     = b;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 40) begin
         if (interfere) begin
            start     = ~start;
            src_a     = $urandom;
            src_b     = $urandom;
            operation = 4'($urandom_range(0, 15));
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
      chk({tag, "_result"}, alu_result, exp_res);
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
      @(posedge clk); #1;
      chk({tag, "_done_cleared"}, {30'd0, busy, done}, 32'd0);
      chk({tag, "_result_held"}, alu_result, exp_res);
   endtask

   initial begin
      int pulses;
      start     = 1'b0;
      operation = 4'd0;
      src_a     = 32'd0;
      src_b     = 32'd0;
      reset     = 1'b0;
      #1 reset  = 1'b1;
      #1;
      chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
      chk("reset_result", alu_result, 32'd0);
      chk("reset_zero", {31'd0, zero}, 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // arithmetic
      run_op("sub",  4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1'b0);

      // asynchronous reset mid-cycle, no clock edge needed
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("async_reset_busy_done", {30'd0, busy, done}, 32'd0);
      chk("async_reset_result", alu_result, 32'd0);
      chk("async_reset_zero", {31'd0, zero}, 32'd1);
      @(negedge clk);
      reset = 1'b0;

      run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1'b0);
      run_op("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 1'b0);
      run_op("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1, 1'b0);

      // iterative shifts
      run_op("sra4", 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, 1'b0);
      run_op("srl4", 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5, 1'b0);
      run_op("sll5", 4'b0100, 32'd1, 32'h25, 32'h0000_0020, 1'b0, 6, 1'b0);

      // compares and branches
      run_op("blt",  4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b0);
      run_op("bge",  4'b1011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1'b0);
      run_op("slt",  4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b0);
      run_op("beq",  4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1'b0);
      run_op("bne",  4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b0);
      run_op("op1111", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1'b0);

      // zero-length shift and a maximal shift with inputs disturbed throughout
      run_op("sll0", 4'b0100, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1, 1'b0);
      run_op("sll31_disturbed", 4'b0100, 32'h0000_0003, 32'd31, 32'h8000_0000, 1'b0, 32, 1'b1);

      // reset while SHIFT holds cnt=10: no done pulse afterwards
      @(negedge clk);
      start     = 1'b1;
      operation = 4'b0100;
      src_a     = 32'd1;
      src_b     = 32'd10;
      @(posedge clk); #3;
      start = 1'b0;
      reset = 1'b1;
      #1;
      chk("shift_reset_busy_done", {30'd0, busy, done}, 32'd0);
      chk("shift_reset_result", alu_result, 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      chk("shift_reset_no_done", 32'(pulses), 32'd0);
      run_op("or_after_reset", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1, 1'b0);

      // start held high: one single-cycle op every two cycles
      @(negedge clk);
      start     = 1'b1;
      operation = 4'b0010;
      src_a     = 32'd1;
      src_b     = 32'd2;
      pulses    = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      start = 1'b0;
      chk("back_to_back_pulses", 32'(pulses), 32'd3);
      chk("back_to_back_result", alu_result, 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
